// File: rtl/life_pkg.sv
// Shared types and constants for the cellular-automaton engine.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_SWAP = 2'd3
    } state_t;

    // Neighbour offsets use two-bit codes: -1, 0, +1.
    localparam logic [1:0] D_NEG  = 2'b11;
    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_POS  = 2'b01;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } offset_t;

    localparam int unsigned PHASE_W      = 4;
    localparam logic [3:0]  DECIDE_PHASE = 4'd8;

    // Fibonacci taps 16,14,13,11 on a right-shifting register: bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [8:0] BIRTH_B3    = 9'h008;
    localparam logic [8:0] SURVIVE_S23 = 9'h00C;

    function automatic offset_t nbr_offset(input logic [2:0] k);
        offset_t o;
        case (k)
            3'd0:    o = '{dx: D_NEG,  dy: D_POS};
            3'd1:    o = '{dx: D_ZERO, dy: D_POS};
            3'd2:    o = '{dx: D_POS,  dy: D_POS};
            3'd3:    o = '{dx: D_NEG,  dy: D_ZERO};
            3'd4:    o = '{dx: D_POS,  dy: D_ZERO};
            3'd5:    o = '{dx: D_NEG,  dy: D_NEG};
            3'd6:    o = '{dx: D_ZERO, dy: D_NEG};
            default: o = '{dx: D_POS,  dy: D_NEG};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/life_if.sv
// Control, pattern-write, display-read and status bundle of the life engine.
interface life_if #(
    parameter int unsigned LOG_W = 6,
    parameter int unsigned LOG_H = 5
);
    localparam int unsigned A = LOG_W + LOG_H;

    logic         start;
    logic         randomize_req;
    logic         wrap_mode;
    logic [8:0]   birth_mask;
    logic [8:0]   survive_mask;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic         wr_data;
    logic [A-1:0] rd_addr;
    logic         rd_data;
    logic         busy;
    logic         gen_done;
    logic [15:0]  generation;
    logic [A:0]   population;

    modport master (
        output start, randomize_req, wrap_mode, birth_mask, survive_mask,
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, gen_done, generation, population
    );

    modport slave (
        input  start, randomize_req, wrap_mode, birth_mask, survive_mask,
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, gen_done, generation, population
    );
endinterface

// File: rtl/life_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; bit 0 feeds the random board fill.
module life_lfsr
    import life_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    output logic rnd_bit
);
    logic [15:0] value_q;
    logic        feedback_c;

    assign feedback_c = ^(value_q & LFSR_TAPS);
    assign rnd_bit    = value_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= SEED;
        else        value_q <= {feedback_c, value_q[15:1]};
    end
endmodule

// File: rtl/life_engine.sv
// Double-buffered Life-like automaton: one cell per 9 cycles, rule set by
// birth/survive masks, with random fill, pattern write and display read.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned LOG_W = 6,
    parameter int unsigned LOG_H = 5,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic  clk,
    input  logic  rst_n,
    life_if.slave bus
);
    localparam int unsigned A  = LOG_W + LOG_H;
    localparam int unsigned N  = 1 << A;
    localparam int unsigned PW = A + 1;

    state_t             state, state_d;
    logic               sel;
    logic [N-1:0]       buf0, buf1;
    logic [A-1:0]       idx;
    logic [PHASE_W-1:0] phase;
    logic [3:0]         nbr_cnt;
    logic [A:0]         pop_acc;
    logic               wrap_q;
    logic [8:0]         birth_q, surv_q;
    logic               rnd_bit;

    logic               host_we_c, init_we_c, scan_we_c;
    logic [N-1:0]       front_c;
    logic [LOG_W-1:0]   x_c, nx_c;
    logic [LOG_H-1:0]   y_c, ny_c;
    logic               x_out_c, y_out_c;
    offset_t            off_c;
    logic               nbr_live_c, self_live_c, next_live_c;
    logic               front_we_c, front_din_c;
    logic [A-1:0]       front_addr_c;
    logic               buf0_we_c, buf1_we_c, buf0_din_c, buf1_din_c;
    logic [A-1:0]       buf0_addr_c, buf1_addr_c;

    life_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .rnd_bit (rnd_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_d;
    end

    // Next state and per-cycle write strobes.
    always_comb begin
        state_d   = state;
        host_we_c = 1'b0;
        init_we_c = 1'b0;
        scan_we_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                host_we_c = bus.wr_en;
                if (bus.randomize_req) state_d = ST_INIT;
                else if (bus.start)    state_d = ST_SCAN;
            end
            ST_INIT: begin
                init_we_c = 1'b1;
                if (&idx) state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (phase == DECIDE_PHASE) begin
                    scan_we_c = 1'b1;
                    if (&idx) state_d = ST_SWAP;
                end
            end
            ST_SWAP: state_d = ST_IDLE;
        endcase
    end

    // Neighbour address for the current phase; edge flags drive dead-edge mode.
    always_comb begin
        front_c = sel ? buf1 : buf0;
        x_c     = idx[LOG_W-1:0];
        y_c     = idx[A-1:LOG_W];
        off_c   = nbr_offset(phase[2:0]);
        nx_c    = x_c;
        ny_c    = y_c;
        x_out_c = 1'b0;
        y_out_c = 1'b0;
        case (off_c.dx)
            D_NEG:   begin nx_c = x_c - LOG_W'(1); x_out_c = (x_c == '0); end
            D_POS:   begin nx_c = x_c + LOG_W'(1); x_out_c = (x_c == '1); end
            default: ;
        endcase
        case (off_c.dy)
            D_NEG:   begin ny_c = y_c - LOG_H'(1); y_out_c = (y_c == '0); end
            D_POS:   begin ny_c = y_c + LOG_H'(1); y_out_c = (y_c == '1); end
            default: ;
        endcase
        nbr_live_c  = front_c[{ny_c, nx_c}] & (wrap_q | ~(x_out_c | y_out_c));
        self_live_c = front_c[idx];
        next_live_c = self_live_c ? surv_q[nbr_cnt] : birth_q[nbr_cnt];
    end

    // Route front-side writes (host/INIT) and back-side writes (SCAN) to buffers.
    always_comb begin
        front_we_c   = host_we_c | init_we_c;
        front_addr_c = init_we_c ? idx : bus.wr_addr;
        front_din_c  = init_we_c ? rnd_bit : bus.wr_data;
        buf0_we_c    = sel ? scan_we_c   : front_we_c;
        buf0_addr_c  = sel ? idx         : front_addr_c;
        buf0_din_c   = sel ? next_live_c : front_din_c;
        buf1_we_c    = sel ? front_we_c  : scan_we_c;
        buf1_addr_c  = sel ? front_addr_c : idx;
        buf1_din_c   = sel ? front_din_c : next_live_c;
    end

    always_ff @(posedge clk) begin
        if (buf0_we_c) buf0[buf0_addr_c] <= buf0_din_c;
        if (buf1_we_c) buf1[buf1_addr_c] <= buf1_din_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel            <= 1'b0;
            idx            <= '0;
            phase          <= '0;
            nbr_cnt        <= '0;
            pop_acc        <= '0;
            wrap_q         <= 1'b0;
            birth_q        <= '0;
            surv_q         <= '0;
            bus.busy       <= 1'b1;
            bus.gen_done   <= 1'b0;
            bus.generation <= '0;
            bus.population <= '0;
            bus.rd_data    <= 1'b0;
        end else begin
            bus.busy     <= (state_d != ST_IDLE);
            bus.gen_done <= (state == ST_SWAP);
            bus.rd_data  <= front_c[bus.rd_addr];
            unique case (state)
                ST_IDLE: begin
                    idx     <= '0;
                    phase   <= '0;
                    nbr_cnt <= '0;
                    pop_acc <= '0;
                    if (state_d == ST_SCAN) begin
                        wrap_q  <= bus.wrap_mode;
                        birth_q <= bus.birth_mask;
                        surv_q  <= bus.survive_mask;
                    end
                end
                ST_INIT: begin
                    idx     <= idx + A'(1);
                    pop_acc <= pop_acc + PW'(rnd_bit);
                    if (&idx) begin
                        bus.generation <= '0;
                        bus.population <= pop_acc + PW'(rnd_bit);
                    end
                end
                ST_SCAN: begin
                    if (phase == DECIDE_PHASE) begin
                        phase   <= '0;
                        nbr_cnt <= '0;
                        idx     <= idx + A'(1);
                        pop_acc <= pop_acc + PW'(next_live_c);
                    end else begin
                        phase   <= phase + PHASE_W'(1);
                        nbr_cnt <= nbr_cnt + 4'(nbr_live_c);
                    end
                end
                ST_SWAP: begin
                    sel            <= ~sel;
                    bus.population <= pop_acc;
                    bus.generation <= bus.generation + 16'd1;
                end
            endcase
        end
    end
endmodule
